// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit sitting beside the single-cycle ALU.
// Computes MUL (low word), UMULL, SMULL (64-bit products) and unsigned DIV
// one bit per cycle, then returns the result with a one-cycle done pulse.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [1:0]       flags,
  output logic             illegal
);

  localparam logic [3:0] OP_MUL   = 4'b0100;
  localparam logic [3:0] OP_UMULL = 4'b0110;
  localparam logic [3:0] OP_SMULL = 4'b1000;
  localparam logic [3:0] OP_DIV   = 4'b0111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  state_t            state_q;
  logic [CNTW-1:0]   cnt_q;
  logic [3:0]        op_q;
  logic [WIDTH-1:0]  mcand_q;   // multiplicand, or divisor for DIV
  logic [WIDTH-1:0]  hi_q;      // product high half, or partial remainder
  logic [WIDTH-1:0]  lo_q;      // multiplier shifting out / product low, or dividend -> quotient
  logic              sign_q;    // SMULL result must be negated
  logic              busy_q;
  logic              done_q;
  logic              illegal_q;
  logic [WIDTH-1:0]  res_lo_q;
  logic [WIDTH-1:0]  res_hi_q;
  logic [1:0]        flags_q;

  logic [WIDTH-1:0]  hi_d;
  logic [WIDTH-1:0]  lo_d;
  logic [WIDTH:0]    mul_sum_s;
  logic [WIDTH:0]    rem_shift_s;
  logic [WIDTH:0]    div_diff_s;
  logic              div_ge_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0]  fix_lo_s;
  logic [WIDTH-1:0]  fix_hi_s;
  logic [1:0]        fix_flags_s;

  // Magnitude of a two's-complement operand; 0x80..0 maps to itself, read as unsigned.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      abs_val = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      abs_val = v;
    end
  endfunction

  assign busy      = busy_q;
  assign done      = done_q;
  assign result_lo = res_lo_q;
  assign result_hi = res_hi_q;
  assign flags     = flags_q;
  assign illegal   = illegal_q;

  // One iteration: shift-add multiply step (LSB first) or restoring divide step (MSB first).
  always_comb begin
    mul_sum_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    rem_shift_s = {hi_q, lo_q[WIDTH-1]};
    div_diff_s  = rem_shift_s - {1'b0, mcand_q};
    // The shifted remainder is below twice the divisor, so the top bit of the
    // difference is a clean borrow indicator.
    div_ge_s    = ~div_diff_s[WIDTH];
    if (op_q == OP_DIV) begin
      hi_d = div_ge_s ? div_diff_s[WIDTH-1:0] : rem_shift_s[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], div_ge_s};
    end else begin
      hi_d = mul_sum_s[WIDTH:1];
      lo_d = {mul_sum_s[0], lo_q[WIDTH-1:1]};
    end
  end

  // Final sign correction and result/flag selection applied in the FIX cycle.
  always_comb begin
    prod_s = {hi_q, lo_q};
    if ((op_q == OP_SMULL) && sign_q) begin
      prod_fix_s = ~prod_s + {{(2*WIDTH-1){1'b0}}, 1'b1};
    end else begin
      prod_fix_s = prod_s;
    end
    case (op_q)
      OP_MUL: begin
        fix_lo_s    = lo_q;
        fix_hi_s    = {WIDTH{1'b0}};
        fix_flags_s = {lo_q[WIDTH-1], (lo_q == {WIDTH{1'b0}})};
      end
      OP_UMULL, OP_SMULL: begin
        fix_lo_s    = prod_fix_s[WIDTH-1:0];
        fix_hi_s    = prod_fix_s[2*WIDTH-1:WIDTH];
        fix_flags_s = {prod_fix_s[2*WIDTH-1], (prod_fix_s == {(2*WIDTH){1'b0}})};
      end
      OP_DIV: begin
        fix_lo_s    = lo_q;
        fix_hi_s    = hi_q;
        fix_flags_s = {lo_q[WIDTH-1], (lo_q == {WIDTH{1'b0}})};
      end
      default: begin
        fix_lo_s    = {WIDTH{1'b0}};
        fix_hi_s    = {WIDTH{1'b0}};
        fix_flags_s = 2'b00;
      end
    endcase
  end

  // Control FSM with the datapath registers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CNTW{1'b0}};
      op_q      <= 4'b0000;
      mcand_q   <= {WIDTH{1'b0}};
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      sign_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      res_lo_q  <= {WIDTH{1'b0}};
      res_hi_q  <= {WIDTH{1'b0}};
      flags_q   <= 2'b00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q   <= op;
            busy_q <= 1'b1;
            cnt_q  <= {CNTW{1'b0}};
            hi_q   <= {WIDTH{1'b0}};
            sign_q <= 1'b0;
            case (op)
              OP_MUL, OP_UMULL: begin
                mcand_q <= a;
                lo_q    <= b;
                state_q <= S_RUN;
              end
              OP_SMULL: begin
                mcand_q <= abs_val(a);
                lo_q    <= abs_val(b);
                sign_q  <= a[WIDTH-1] ^ b[WIDTH-1];
                state_q <= S_RUN;
              end
              OP_DIV: begin
                mcand_q <= b;
                lo_q    <= a;
                if (b == {WIDTH{1'b0}}) begin
                  // Divide by zero short-circuits straight to DONE.
                  res_lo_q  <= {WIDTH{1'b1}};
                  res_hi_q  <= a;
                  flags_q   <= 2'b10;
                  illegal_q <= 1'b0;
                  done_q    <= 1'b1;
                  state_q   <= S_DONE;
                end else begin
                  state_q <= S_RUN;
                end
              end
              default: begin
                mcand_q   <= a;
                lo_q      <= b;
                res_lo_q  <= {WIDTH{1'b0}};
                res_hi_q  <= {WIDTH{1'b0}};
                flags_q   <= 2'b00;
                illegal_q <= 1'b1;
                done_q    <= 1'b1;
                state_q   <= S_DONE;
              end
            endcase
          end
        end
        S_RUN: begin
          hi_q <= hi_d;
          lo_q <= lo_d;
          if (cnt_q == CNTW'(WIDTH-1)) begin
            cnt_q   <= {CNTW{1'b0}};
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
          end
        end
        S_FIX: begin
          res_lo_q  <= fix_lo_s;
          res_hi_q  <= fix_hi_s;
          flags_q   <= fix_flags_s;
          illegal_q <= 1'b0;
          done_q    <= 1'b1;
          state_q   <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares whenever done is seen.
module tb_muldiv_unit;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic [1:0]  fl;
    logic        il;
    int          dcyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = 4'b0000;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        busy, done, illegal;
  logic [31:0] result_lo, result_hi;
  logic [1:0]  flags;

  exp_t q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(32), .CNTW(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
    .flags(flags), .illegal(illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.dcyc));
        chk("result_lo", 64'(result_lo), 64'(e.lo));
        chk("result_hi", 64'(result_hi), 64'(e.hi));
        chk("flags", 64'(flags), 64'(e.fl));
        chk("illegal", 64'(illegal), 64'(e.il));
        chk("busy_at_done", 64'(busy), 64'd1);
      end
    end
  end

  // Called at posedge+1; leaves start high across one edge, then scrambles inputs.
  task automatic issue(input logic [3:0] o, input logic [31:0] aa, input logic [31:0] bb,
                       input logic [31:0] elo, input logic [31:0] ehi,
                       input logic [1:0] efl, input logic eil, input int lat);
    exp_t e;
    start = 1'b1;
    op = o;
    a = aa;
    b = bb;
    e.lo = elo; e.hi = ehi; e.fl = efl; e.il = eil; e.dcyc = cyc + lat;
    q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 4'($urandom_range(15, 0));
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL done_timeout: got no done in %0d cycles expected done", budget);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_lo", 64'(result_lo), 64'd0);
    chk("rst_hi", 64'(result_hi), 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    chk("rst_illegal", 64'(illegal), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed vectors: op, a, b, lo, hi, {N,Z}, illegal, latency
    issue(4'b0110, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 2'b10, 1'b0, 34);
    chk("busy_running", 64'(busy), 64'd1);
    wait_done(60);
    issue(4'b1000, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 32'hFFFFFFFF, 2'b10, 1'b0, 34);
    wait_done(60);
    issue(4'b1000, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 2'b00, 1'b0, 34);
    wait_done(60);
    issue(4'b1000, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFF2, 32'hFFFFFFFF, 2'b10, 1'b0, 34);
    wait_done(60);
    issue(4'b0100, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000000, 2'b01, 1'b0, 34);
    wait_done(60);
    issue(4'b0100, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'h00000000, 2'b10, 1'b0, 34);
    wait_done(60);
    issue(4'b0111, 32'h00000064, 32'h00000007, 32'h0000000E, 32'h00000002, 2'b00, 1'b0, 34);
    wait_done(60);
    issue(4'b0111, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 32'h0000000F, 2'b00, 1'b0, 34);
    wait_done(60);
    issue(4'b0111, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 32'h12345678, 2'b10, 1'b0, 1);
    wait_done(10);
    issue(4'b0010, 32'h11111111, 32'h22222222, 32'h00000000, 32'h00000000, 2'b00, 1'b1, 1);
    wait_done(10);

    // Start pulses while busy are ignored
    issue(4'b0110, 32'h00001234, 32'h00000010, 32'h00012340, 32'h00000000, 2'b00, 1'b0, 34);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; op = 4'b0111; a = 32'h00000100; b = 32'h00000003;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (27) @(posedge clk);
    #1;
    start = 1'b1; op = 4'b0110; a = 32'h0000FFFF; b = 32'h0000FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(10);
    chk("busy_after_done", 64'(busy), 64'd0);
    // Start in the cycle right after done is accepted
    issue(4'b0111, 32'h00000064, 32'h00000007, 32'h0000000E, 32'h00000002, 2'b00, 1'b0, 34);
    wait_done(60);

    // Reset in the middle of a DIV aborts it
    issue(4'b0111, 32'h00001000, 32'h00000003, 32'h00000555, 32'h00000001, 2'b00, 1'b0, 34);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    issue(4'b0100, 32'h00000003, 32'h00000004, 32'h0000000C, 32'h00000000, 2'b00, 1'b0, 34);
    wait_done(60);

    repeat (40) @(posedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
